// File: rtl/rob_commit_unit_pkg.sv
// Shared widths, the NULL index, FSM encodings and the RB table entry type
// used by the reorder-buffer commit stage.
package rob_commit_unit_pkg;
   localparam int WORD_SIZE = 32;
   localparam int RB_SIZE   = 8;
   localparam int RB_INDEX  = 4;
   localparam int REG_INDEX = 5;
   localparam int PTR_W     = $clog2(RB_SIZE);

   localparam logic [RB_INDEX-1:0] NULL = 4'b1111;

   localparam logic ST_RUN        = 1'b0;
   localparam logic ST_STORE_WAIT = 1'b1;

   typedef enum logic {
      RUN        = ST_RUN,
      STORE_WAIT = ST_STORE_WAIT
   } state_t;

   typedef struct packed {
      logic [REG_INDEX-1:0] dest;
      logic                 is_store;
   } rb_entry_t;
endpackage

// File: rtl/rob_commit_unit_if.sv
// Dispatch, CDB result arrays, register-file write and store handshake of the
// commit stage. master is the commit unit, slave is its surroundings.
interface rob_commit_unit_if;
   import rob_commit_unit_pkg::*;

   logic                         dispatch_valid;
   logic [REG_INDEX-1:0]         dispatch_dest;
   logic                         dispatch_is_store;
   logic [RB_INDEX-1:0]          RB_alloc_index;
   logic                         RB_full;
   logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
   logic [RB_SIZE-1:0]           CDB_data_valid;
   logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
   logic [RB_SIZE-1:0]           RB_release;
   logic                         rf_we;
   logic [REG_INDEX-1:0]         rf_waddr;
   logic [WORD_SIZE-1:0]         rf_wdata;
   logic                         mem_req;
   logic [WORD_SIZE-1:0]         mem_addr;
   logic [WORD_SIZE-1:0]         mem_wdata;
   logic                         mem_ack;
   logic                         flush;

   modport master (
      input  dispatch_valid, dispatch_dest, dispatch_is_store,
      input  CDB_data_data, CDB_data_valid, CDB_data_addr, mem_ack, flush,
      output RB_alloc_index, RB_full, RB_release,
      output rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata
   );

   modport slave (
      output dispatch_valid, dispatch_dest, dispatch_is_store,
      output CDB_data_data, CDB_data_valid, CDB_data_addr, mem_ack, flush,
      input  RB_alloc_index, RB_full, RB_release,
      input  rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rob_commit_unit_rb_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer; pointers wrap modulo
// RB_SIZE, count spans 0..RB_SIZE so full and empty are distinguishable.
module rb_ptr_ctrl
   import rob_commit_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (PTR_W+1)'(RB_SIZE));
   assign empty = (count == '0);
endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement of reorder-buffer entries: register results go to the
// register file, stores go out over mem_req/mem_ack, each retire releases its entry.
module rob_commit_unit
   import rob_commit_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   rob_commit_unit_if.master  bus
);
   state_t           state_q, state_n;
   logic             flush_pend_q;
   rb_entry_t        tbl [RB_SIZE];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;
   logic             full, empty;
   logic             push, pop, clear, start_store, rf_fire, set_pend;
   logic             head_vld;
   rb_entry_t        head_ent;

   function automatic logic [WORD_SIZE-1:0] word_at(
      input logic [WORD_SIZE*RB_SIZE-1:0] words,
      input logic [PTR_W-1:0]             idx
   );
      return words[int'(idx)*WORD_SIZE +: WORD_SIZE];
   endfunction

   // Entries from head onward for count slots, used to release everything on flush.
   function automatic logic [RB_SIZE-1:0] live_mask(
      input logic [PTR_W-1:0] h,
      input logic [PTR_W:0]   c
   );
      logic [PTR_W-1:0] off;
      for (int i = 0; i < RB_SIZE; i++) begin
         off          = PTR_W'(i) - h;
         live_mask[i] = ({1'b0, off} < c);
      end
   endfunction

   rb_ptr_ctrl u_ptr (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .head  (head),
      .tail  (tail),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign head_vld = bus.CDB_data_valid[head] && !empty;
   assign head_ent = tbl[head];
   assign push     = bus.dispatch_valid && !full && !bus.flush && !flush_pend_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_n;
   end

   always_comb begin
      state_n     = state_q;
      pop         = 1'b0;
      clear       = 1'b0;
      start_store = 1'b0;
      rf_fire     = 1'b0;
      set_pend    = 1'b0;
      case (state_q)
         RUN: begin
            // A deferred flush from STORE_WAIT lands here the cycle after the ack.
            if (bus.flush || flush_pend_q) begin
               clear = 1'b1;
            end else if (head_vld) begin
               if (head_ent.is_store) begin
                  start_store = 1'b1;
                  state_n     = STORE_WAIT;
               end else begin
                  rf_fire = 1'b1;
                  pop     = 1'b1;
               end
            end
         end
         STORE_WAIT: begin
            if (bus.flush) set_pend = 1'b1;
            if (bus.mem_ack) begin
               pop     = 1'b1;
               state_n = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) tbl[tail] <= '{dest: bus.dispatch_dest, is_store: bus.dispatch_is_store};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flush_pend_q   <= 1'b0;
         bus.rf_we      <= 1'b0;
         bus.rf_waddr   <= '0;
         bus.rf_wdata   <= '0;
         bus.mem_req    <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.RB_release <= '0;
      end else begin
         bus.rf_we      <= rf_fire;
         bus.RB_release <= '0;
         if (rf_fire) begin
            bus.rf_waddr <= head_ent.dest;
            bus.rf_wdata <= word_at(bus.CDB_data_data, head);
         end
         if (pop)   bus.RB_release <= RB_SIZE'(1) << head;
         if (clear) bus.RB_release <= live_mask(head, count);
         if (start_store) begin
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= word_at(bus.CDB_data_addr, head);
            bus.mem_wdata <= word_at(bus.CDB_data_data, head);
         end else if (state_q == STORE_WAIT && bus.mem_ack) begin
            bus.mem_req <= 1'b0;
         end
         if (set_pend)   flush_pend_q <= 1'b1;
         else if (clear) flush_pend_q <= 1'b0;
      end
   end

   assign bus.RB_full        = full;
   assign bus.RB_alloc_index = full ? NULL : {1'b0, tail};
endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

In-order retirement stage of the Tomasulo core: the consumer end of the CDB result arrays driven by `CDB_data_controller`. Allocates reorder-buffer (RB) entries at dispatch, watches the per-entry valid/data/address arrays, and retires the head entry once its result is valid. A register result is written to the register file; a store is sent to memory over a req/ack handshake. Each retire pulses a release bit back to the data controller so the entry's valid is cleared before reuse.

## Interface
Parameters (shared values in `parameters.v`):
- WORD_SIZE, 32, data/address width
- RB_SIZE, 8, RB entries (power of two)
- RB_INDEX, 4, RB index width (one spare bit so NULL fits)
- NULL, 4'b1111, "no entry" index value
- REG_INDEX, 5, register-file address width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- dispatch_valid  in  1  allocate an entry this cycle
- dispatch_dest  in  REG_INDEX  destination register (ignored for stores)
- dispatch_is_store  in  1  entry is a store
- RB_alloc_index  out  RB_INDEX  tail index; NULL when full
- RB_full  out  1  count == RB_SIZE
- CDB_data_data  in  WORD_SIZE*RB_SIZE  result per entry, entry k at bits [k*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  result-valid per entry
- CDB_data_addr  in  WORD_SIZE*RB_SIZE  store address per entry
- RB_release  out  RB_SIZE  one-cycle one-hot pulse; clears the entry's CDB valid
- rf_we  out  1  register write strobe
- rf_waddr  out  REG_INDEX  register address
- rf_wdata  out  WORD_SIZE  register data
- mem_req  out  1  store request, held until ack
- mem_addr  out  WORD_SIZE  store address
- mem_wdata  out  WORD_SIZE  store data
- mem_ack  in  1  store accepted
- flush  in  1  discard all entries (mispredict)

## Operation
- State: head, tail (log2 RB_SIZE bits, wrap modulo RB_SIZE), count (0..RB_SIZE), per-entry dest/is_store table, FSM {RUN, STORE_WAIT}, flush_pending.
- Dispatch: if dispatch_valid && !RB_full, the table at tail gets {dest, is_store}; tail++ and count++. Dispatch while full is dropped silently. RB_alloc_index shows the current tail, or NULL when full.
- RUN: if count != 0 && CDB_data_valid[head]:
  - Register entry: rf_we=1, rf_waddr=dest, rf_wdata=data[head]. RB_release[head] pulses, head++, count--.
  - Store entry: latch addr[head] and data[head] into mem_addr and mem_wdata, set mem_req=1, go to STORE_WAIT.
- STORE_WAIT: hold mem_req, mem_addr and mem_wdata stable. On mem_ack: mem_req=0, pulse RB_release[head], head++, count--, return to RUN. Nothing retires while waiting.
- At most one retire per cycle.
- Same-cycle dispatch and retire: count is unchanged, and head and tail both advance.
- Flush in RUN: head=tail=count=0 next cycle. Any retire decision in that cycle is suppressed: no rf_we, no release.
- Flush in STORE_WAIT: set flush_pending. The outstanding store completes and retires on ack. Apply the flush in the cycle after ack. Dispatch is blocked while flush_pending is set.
- On flush, RB_release pulses all bits of the non-empty entries.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, mem_req=0, mem_addr=0, mem_wdata=0, RB_release=0, RB_full=0, RB_alloc_index=0, head=tail=count=0, FSM=RUN, flush_pending=0.
- All outputs are registered.
- CDB arrays update on negedge clk; this block samples them on posedge, a half cycle later.
- Latency: a valid seen at posedge N gives rf_we high during cycle N+1, with RB_release in the same cycle. The data controller clears the valid at negedge N+1, so the posedge N+2 sample is clean.
- Store path: mem_req rises in cycle N+1. If mem_ack is high at posedge M, mem_req is low and the release pulses in cycle M+1.
- Reset mid-store drops mem_req next cycle with no retire.

## Structure
- The width constants above and the NULL value live in the shared `parameters.v`.
- FSM state encodings are local parameters.
- Optional sub-module `rb_ptr_ctrl`: head, tail and count with wrap and full/empty logic.
- Data/address slice extraction is an in-module function.

## Test plan
- Dispatch dest=3, then CDB valid[0] with data=0x1234 -> rf_we for one cycle, rf_waddr=3, rf_wdata=0x1234, RB_release=8'b00000001.
- Dispatch 8 entries -> RB_full=1, RB_alloc_index=NULL; a 9th dispatch is ignored. Retire one -> tail wraps to 0, RB_alloc_index=0.
- Entry 1 valid before entry 0 -> no retire until entry 0 is valid; then two retires in consecutive cycles, in order 0 then 1.
- Store at entry 0 (addr=0x40, data=0xBEEF), ack held off 3 cycles -> mem_req stable for 4 cycles with fields unchanged; release after ack.
- Flush during STORE_WAIT with 3 entries live -> the store retires, then count=0; the other 2 entries get RB_release and no rf_we.
- Reset asserted during STORE_WAIT -> all outputs are at reset values next cycle and mem_req=0.
